fifo_sync_flags: RTL and testbench
==================================

// Module: fifo_sync_flags
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the basic buffer.
//   Adds configurable width/depth, an occupancy count, and programmable almost-full/empty flags.
//   Also adds sticky overflow/underflow errors, a synchronous flush, and a first-word-fall-through mode.
//   Sits between a producer and a consumer stage in the same clock domain.
// PARAMETERS
//   DATA_WIDTH  8   word width in bits (>=1)
//   DEPTH       16  number of entries (>=2, need not be a power of 2)
//   FWFT        0   0: registered read (data 1 cycle after rd_en); 1: head word always on data_o
//   AF_THRESH   14  almost_full_o asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   2   almost_empty_o asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//   clk_i           in   1                    clock, rising edge
//   rst_i           in   1                    synchronous reset, active-high
//   clear_i         in   1                    synchronous flush, same effect as reset
//   wr_en_i         in   1                    write request
//   data_i          in   DATA_WIDTH           write data
//   rd_en_i         in   1                    read (pop) request
//   data_o          out  DATA_WIDTH           read data
//   full_o          out  1                    count == DEPTH
//   empty_o         out  1                    count == 0
//   almost_full_o   out  1                    count >= AF_THRESH
//   almost_empty_o  out  1                    count <= AE_THRESH
//   count_o         out  $clog2(DEPTH+1)      current occupancy
//   overflow_o      out  1                    sticky: write rejected
//   underflow_o     out  1                    sticky: read rejected
// BEHAVIOUR
// - Reset / flush
//   - rst_i or clear_i at a clock edge clears wr_ptr, rd_ptr, count and data_o (all zero).
//   - Sets empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0 (AE_THRESH>=0), overflow_o=0, underflow_o=0.
//   - Takes priority over any wr_en_i/rd_en_i in the same cycle; memory contents need not be cleared.
// - Accept rules (evaluated on registered state before the edge)
//   - rd_acc = rd_en_i & !empty_o.
//   - wr_acc = wr_en_i & (!full_o | rd_acc). Write while full is accepted only if a pop occurs in the same cycle.
//   - Empty + wr_en_i + rd_en_i: write accepted, read rejected, underflow_o set.
// - Pointers
//   - Each pointer is 0..DEPTH-1 and wraps DEPTH-1 -> 0 explicitly (no power-of-2 masking).
//   - wr_acc writes mem[wr_ptr]; rd_acc advances rd_ptr.
// - Count
//   - count += wr_acc - rd_acc.
//   - Unchanged when both accepted; never exceeds DEPTH, never below 0.
// - Flags
//   - full/empty/almost_* are combinational decodes of the count register.
//   - They therefore change in the cycle after the accepting edge.
// - Errors
//   - overflow_o is set at the edge where wr_en_i & !wr_acc.
//   - underflow_o is set at the edge where rd_en_i & !rd_acc.
//   - Both hold until rst_i/clear_i; the rejected operation has no other effect.
// - FWFT=0
//   - data_o <= mem[rd_ptr] on rd_acc, so it is valid the cycle after rd_en_i.
//   - Otherwise data_o holds its last value.
// - FWFT=1
//   - data_o = mem[rd_ptr] whenever !empty_o.
//   - A word is visible the cycle after it is written into an empty FIFO.
//   - rd_acc pops it and presents the next word the following cycle.
//   - data_o is don't-care while empty; the bench must not check it.
// - Simultaneous read/write at full: the pop leaves the slot at rd_ptr; the write lands at wr_ptr (==rd_ptr).
//   - Both pointers advance; count stays DEPTH, full_o stays 1.
// - Reset asserted mid-burst: the next cycle is as after power-up; prior words are lost.
// TESTING (defaults unless noted)
//   1. Reset, then write 5 words A0..A4 (1 per cycle) -> count 5, empty 0, almost_empty 0; read 5 -> data_o A0..A4 in order, count 0, empty 1.
//   2. Write 16 words -> full 1, almost_full asserted at count 14; 17th write -> rejected, overflow 1, count 16; overflow stays 1 until clear_i.
//   3. At full, assert wr_en+rd_en with data 0x5A -> count stays 16; drain 16 -> 0x5A is the last word out.
//   4. At empty, assert rd_en -> underflow 1, count 0; wr_en+rd_en on empty -> count 1, underflow 1.
//   5. DEPTH=5: 3 rounds of write 4 / read 4 (pointer wrap past 4 -> 0) -> data order preserved, no error flags.
//   6. FWFT=1: write 0x11 into empty -> data_o 0x11 next cycle without rd_en; rd_en pops it; clear_i with 3 words -> count 0, empty 1.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with occupancy count, programmable flags and sticky errors
//
// Purpose: parametrised synchronous FIFO between a producer and a consumer in
// one clock domain. Provides occupancy count, full/empty and almost-full/empty
// decodes, sticky overflow/underflow, synchronous flush and an optional
// first-word-fall-through read port.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   clear_i        synchronous flush, same effect as reset
//   wr_en_i        write request
//   data_i         write data
//   rd_en_i        read (pop) request
//   data_o         read data (registered when FWFT=0, head word when FWFT=1)
//   full_o         count == DEPTH
//   empty_o        count == 0
//   almost_full_o  count >= AF_THRESH
//   almost_empty_o count <= AE_THRESH
//   count_o        current occupancy
//   overflow_o     sticky: a write was rejected
//   underflow_o    sticky: a read was rejected
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  flush;
  logic                  rd_acc;
  logic                  wr_acc;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  assign flush = rst_i | clear_i;

  assign full_o         = (count == DEPTH_C);
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= AF_C);
  assign almost_empty_o = (count <= AE_C);
  assign count_o        = count;

  // A write into a full FIFO is allowed only when a pop frees the slot the
  // same cycle; wr_ptr == rd_ptr then, so the new word replaces the popped one.
  assign rd_acc = rd_en_i & ~empty_o;
  assign wr_acc = wr_en_i & (~full_o | rd_acc);

  always_ff @(posedge clk_i) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_ONE;
      end
      if (wr_en_i && !wr_acc) begin
        overflow_o <= 1'b1;
      end
      if (rd_en_i && !rd_acc) begin
        underflow_o <= 1'b1;
      end
    end
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
      if (flush) begin
        data_q <= '0;
      end else if (rd_acc) begin
        data_q <= mem[rd_ptr];
      end
    end

    assign data_o = data_q;
  end else begin : g_fwft_read
    // Head word is driven straight from storage; meaningless while empty.
    assign data_o = mem[rd_ptr];
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - scoreboard bench for fifo_sync_flags (default, DEPTH=5, FWFT=1)
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: defaults (8 x 16, registered read, AF 14, AE 2)
  logic       a_clr = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_cnt;

  // Instance B: DEPTH=5, AF 4, AE 1
  logic       b_clr = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;

  // Instance F: FWFT=1, otherwise defaults
  logic       f_clr = 0, f_wr = 0, f_rd = 0;
  logic [7:0] f_din = 0, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_cnt;

  fifo_sync_flags u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(a_clr), .wr_en_i(a_wr), .data_i(a_din),
    .rd_en_i(a_rd), .data_o(a_dout), .full_o(a_full), .empty_o(a_empty),
    .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_cnt),
    .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  fifo_sync_flags #(.DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(b_clr), .wr_en_i(b_wr), .data_i(b_din),
    .rd_en_i(b_rd), .data_o(b_dout), .full_o(b_full), .empty_o(b_empty),
    .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_cnt),
    .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  fifo_sync_flags #(.FWFT(1)) u_f (
    .clk_i(clk), .rst_i(rst), .clear_i(f_clr), .wr_en_i(f_wr), .data_i(f_din),
    .rd_en_i(f_rd), .data_o(f_dout), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_cnt),
    .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  // Scoreboards and sticky-flag models
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       ovf_a = 0, unf_a = 0, ovf_b = 0, unf_b = 0;
  logic [7:0] last_a = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_state();
    check("a_count", 32'(a_cnt), qa.size());
    check("a_full", 32'(a_full), 32'(qa.size() == 16));
    check("a_empty", 32'(a_empty), 32'(qa.size() == 0));
    check("a_afull", 32'(a_af), 32'(qa.size() >= 14));
    check("a_aempty", 32'(a_ae), 32'(qa.size() <= 2));
    check("a_ovf", 32'(a_ovf), 32'(ovf_a));
    check("a_unf", 32'(a_unf), 32'(unf_a));
  endtask

  // One cycle on instance A; acceptance is predicted from the scoreboard.
  task automatic op_a(input logic w, input logic [7:0] d, input logic r);
    logic ra, wa;
    logic [7:0] exp;
    ra = r && (qa.size() != 0);
    wa = w && ((qa.size() < 16) || ra);
    if (r && !ra) unf_a = 1'b1;
    if (w && !wa) ovf_a = 1'b1;
    a_wr = w; a_din = d; a_rd = r;
    tick();
    a_wr = 0; a_rd = 0;
    if (ra) begin
      exp = qa.pop_front();
      last_a = a_dout;
      check("a_data", 32'(a_dout), 32'(exp));
    end
    if (wa) qa.push_back(d);
    check_a_state();
  endtask

  task automatic op_b(input logic w, input logic [7:0] d, input logic r);
    logic ra, wa;
    logic [7:0] exp;
    ra = r && (qb.size() != 0);
    wa = w && ((qb.size() < 5) || ra);
    if (r && !ra) unf_b = 1'b1;
    if (w && !wa) ovf_b = 1'b1;
    b_wr = w; b_din = d; b_rd = r;
    tick();
    b_wr = 0; b_rd = 0;
    if (ra) begin
      exp = qb.pop_front();
      check("b_data", 32'(b_dout), 32'(exp));
    end
    if (wa) qb.push_back(d);
    check("b_count", 32'(b_cnt), qb.size());
    check("b_full", 32'(b_full), 32'(qb.size() == 5));
    check("b_ovf", 32'(b_ovf), 32'(ovf_b));
    check("b_unf", 32'(b_unf), 32'(unf_b));
  endtask

  initial begin
    // Power-up reset of all instances
    rst = 1;
    tick();
    rst = 0;
    check("rst_dout", 32'(a_dout), 0);
    check_a_state();
    check("rst_b_empty", 32'(b_empty), 1);

    // 1: five words in, five words out
    for (int i = 0; i < 5; i++) op_a(1, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 5; i++) op_a(0, 8'h00, 1);

    // 2: fill to 16 (almost_full from 14), then a rejected 17th write
    for (int i = 0; i < 16; i++) op_a(1, 8'(i * 7 + 3), 0);
    op_a(1, 8'hFF, 0);
    op_a(0, 8'h00, 0);
    check("ovf_sticky", 32'(a_ovf), 1);

    // 3: write+read at full, then drain; 0x5A must be the last word out
    op_a(1, 8'h5A, 1);
    for (int i = 0; i < 16; i++) op_a(0, 8'h00, 1);
    check("last_5a", 32'(last_a), 32'h5A);
    check("ovf_before_clr", 32'(a_ovf), 1);
    a_clr = 1;
    tick();
    a_clr = 0;
    qa.delete(); ovf_a = 0; unf_a = 0;
    check_a_state();

    // 4: underflow on empty, then write+read on empty
    op_a(0, 8'h00, 1);
    op_a(1, 8'h77, 1);
    op_a(0, 8'h00, 1);

    // 5: DEPTH=5 pointer wrap over three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) op_b(1, 8'(8'h40 + r * 16 + i), 0);
      for (int i = 0; i < 4; i++) op_b(0, 8'h00, 1);
    end
    for (int i = 0; i < 5; i++) op_b(1, 8'(8'hC0 + i), 0);
    check("b_afull", 32'(b_af), 1);
    op_b(1, 8'hEE, 1);
    for (int i = 0; i < 5; i++) op_b(0, 8'h00, 1);
    check("b_ae", 32'(b_ae), 1);

    // 6: first-word-fall-through
    f_wr = 1; f_din = 8'h11;
    tick();
    f_wr = 0;
    check("f_head_11", 32'(f_dout), 32'h11);
    check("f_cnt1", 32'(f_cnt), 1);
    f_wr = 1; f_din = 8'h22;
    tick();
    f_wr = 0;
    check("f_head_hold", 32'(f_dout), 32'h11);
    f_rd = 1;
    tick();
    f_rd = 0;
    check("f_head_22", 32'(f_dout), 32'h22);
    f_wr = 1; f_din = 8'h33;
    tick();
    f_din = 8'h44;
    tick();
    f_wr = 0;
    check("f_cnt3", 32'(f_cnt), 3);
    f_clr = 1;
    tick();
    f_clr = 0;
    check("f_clr_cnt", 32'(f_cnt), 0);
    check("f_clr_empty", 32'(f_empty), 1);

    // Reset in the middle of a write burst: prior words are lost
    for (int i = 0; i < 3; i++) op_a(1, 8'hB0 + 8'(i), 0);
    rst = 1; a_wr = 1; a_din = 8'hCC;
    tick();
    rst = 0; a_wr = 0;
    qa.delete(); ovf_a = 0; unf_a = 0;
    check("midrst_dout", 32'(a_dout), 0);
    check_a_state();
    op_a(1, 8'hD1, 0);
    op_a(0, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
